// File: rtl/led_blink_driver.sv
// -----------------------------------------------------------------------------
// led_blink_driver
//
// Accepts blink commands over a valid/ready handshake and drives an
// active-low LED pin with a timed on/off pattern. A command blinks the LED
// cmd_count times. Each blink is on for cmd_on_ticks ticks and then off for
// cmd_off_ticks ticks. One tick is TICK_DIV sys_clk cycles. The trailing off
// phase always completes before done pulses, so back-to-back commands always
// show a visible gap.
//
// Ports
//   sys_clk        in   1      system clock, rising edge
//   sys_rst_n      in   1      synchronous reset, active-low
//   cmd_valid      in   1      command present
//   cmd_ready      out  1      block can accept a command (combinational)
//   cmd_count      in   CNT_W  number of blinks (0 = no blink, done only)
//   cmd_on_ticks   in   PER_W  LED-on time per blink in ticks (0 treated as 1)
//   cmd_off_ticks  in   PER_W  LED-off time per blink in ticks (0 treated as 1)
//   abort          in   1      cancel the current pattern, no done pulse
//   led_1          out  1      LED pin, active-low (0 = lit)
//   busy           out  1      pattern in progress
//   done           out  1      one-cycle pulse when a pattern completes
// -----------------------------------------------------------------------------
module led_blink_driver #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 8,
    parameter int PER_W    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [PER_W-1:0] cmd_on_ticks,
    input  logic [PER_W-1:0] cmd_off_ticks,
    input  logic             abort,
    output logic             led_1,
    output logic             busy,
    output logic             done
);

    // A single-cycle tick (TICK_DIV=1) still needs a 1-bit prescaler.
    localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic               led_q,       led_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [PER_W-1:0]   on_per_q,    on_per_d;
    logic [PER_W-1:0]   off_per_q,   off_per_d;
    logic [PRE_W-1:0]   pre_q,       pre_d;
    logic [PER_W-1:0]   tick_cnt_q,  tick_cnt_d;

    logic               accept;
    logic               tick;
    logic [PER_W-1:0]   cur_per;
    logic               phase_end;

    assign cmd_ready = (state_q == S_IDLE) & ~abort & sys_rst_n;
    assign accept    = cmd_valid & cmd_ready;

    // The prescaler raises tick on its last count; a phase ends on the tick
    // that completes its final period tick, so a phase lasts exactly
    // period*TICK_DIV cycles measured from the edge that entered it.
    assign tick      = (pre_q == PRE_MAX);
    assign cur_per   = (state_q == S_ON) ? on_per_q : off_per_q;
    assign phase_end = tick && (tick_cnt_q == (cur_per - PER_W'(1)));

    assign led_1 = led_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        on_per_d    = on_per_q;
        off_per_d   = off_per_q;
        pre_d       = pre_q;
        tick_cnt_d  = tick_cnt_q;

        case (state_q)
            S_IDLE: begin
                led_d  = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    on_per_d  = (cmd_on_ticks  == '0) ? PER_W'(1) : cmd_on_ticks;
                    off_per_d = (cmd_off_ticks == '0) ? PER_W'(1) : cmd_off_ticks;
                    pre_d      = '0;
                    tick_cnt_d = '0;
                    if (cmd_count == '0) begin
                        // Empty pattern: complete immediately without leaving IDLE.
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_ON;
                        led_d       = 1'b0;
                        busy_d      = 1'b1;
                        remaining_d = cmd_count;
                    end
                end
            end

            S_ON, S_OFF: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    led_d       = 1'b1;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    pre_d       = '0;
                    tick_cnt_d  = '0;
                end else begin
                    pre_d = tick ? '0 : pre_q + PRE_W'(1);
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + PER_W'(1);
                    end
                    if (phase_end) begin
                        tick_cnt_d = '0;
                        if (state_q == S_ON) begin
                            state_d = S_OFF;
                            led_d   = 1'b1;
                        end else if (remaining_q > CNT_W'(1)) begin
                            state_d     = S_ON;
                            led_d       = 1'b0;
                            remaining_d = remaining_q - CNT_W'(1);
                        end else begin
                            state_d     = S_IDLE;
                            led_d       = 1'b1;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            remaining_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                led_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            led_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            on_per_q    <= '0;
            off_per_q   <= '0;
            pre_q       <= '0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            on_per_q    <= on_per_d;
            off_per_q   <= off_per_d;
            pre_q       <= pre_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

endmodule

// File: tb/tb_led_blink_driver.sv
// -----------------------------------------------------------------------------
// tb_led_blink_driver
//
// Two instances: dut0 with TICK_DIV=4 and dut1 with TICK_DIV=1. A model
// describes each pattern arithmetically: k cycles after the accepting edge,
// blink index k/P and position k%P (P = N+F) give the LED level, and the
// pattern ends at k = count*P. It is checked against both DUTs on every
// falling edge. Literal checks pin the done latencies and the handshake
// corner cases.
// -----------------------------------------------------------------------------
module tb_led_blink_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        valid   [2];
    logic        abort_s [2];
    logic [7:0]  cnt_s   [2];
    logic [15:0] on_s    [2];
    logic [15:0] off_s   [2];
    logic        ready   [2];
    logic        led     [2];
    logic        busy    [2];
    logic        done    [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    led_blink_driver #(.TICK_DIV(4), .CNT_W(8), .PER_W(16)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n[0]), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
        .cmd_count(cnt_s[0]), .cmd_on_ticks(on_s[0]), .cmd_off_ticks(off_s[0]),
        .abort(abort_s[0]), .led_1(led[0]), .busy(busy[0]), .done(done[0])
    );

    led_blink_driver #(.TICK_DIV(1), .CNT_W(8), .PER_W(16)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n[1]), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
        .cmd_count(cnt_s[1]), .cmd_on_ticks(on_s[1]), .cmd_off_ticks(off_s[1]),
        .abort(abort_s[1]), .led_1(led[1]), .busy(busy[1]), .done(done[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, idx, act, exp, cyc);
        end
    endtask

    function automatic int td(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int at_least_1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // ---------------- model ----------------
    bit m_act  [2] = '{0, 0};
    bit m_done [2] = '{0, 0};
    int m_k    [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_n    [2] = '{1, 1};
    int m_p    [2] = '{2, 2};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else if (m_act[i]) begin
                m_done[i] = 1'b0;
                if (abort_s[i]) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_k[i]++;
                    if (m_k[i] == m_cnt[i] * m_p[i]) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else begin
                m_done[i] = 1'b0;
                if (valid[i] && !abort_s[i]) begin
                    if (cnt_s[i] == 8'd0) begin
                        m_done[i] = 1'b1;
                    end else begin
                        m_act[i] = 1'b1;
                        m_k[i]   = 0;
                        m_cnt[i] = int'(cnt_s[i]);
                        m_n[i]   = at_least_1(int'(on_s[i])) * td(i);
                        m_p[i]   = m_n[i] + at_least_1(int'(off_s[i])) * td(i);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("led",   i, 32'(led[i]),   32'(m_act[i] ? (((m_k[i] % m_p[i]) < m_n[i]) ? 0 : 1) : 1));
            chk("busy",  i, 32'(busy[i]),  32'(m_act[i]));
            chk("done",  i, 32'(done[i]),  32'(m_done[i]));
            chk("ready", i, 32'(ready[i]), 32'(!m_act[i] && rst_n[i] && !abort_s[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a command and wait for the accepting edge; acc = cycle index of that edge.
    task automatic issue(input int i, input int c, input int on, input int off,
                         input bit keep, output int acc);
        acc = -1;
        valid[i] = 1'b1;
        cnt_s[i] = 8'(c);
        on_s[i]  = 16'(on);
        off_s[i] = 16'(off);
        for (int t = 0; t < 200; t++) begin
            if (ready[i] === 1'b1) begin
                step(1);
                acc = cyc;
                break;
            end
            step(1);
        end
        if (!keep) valid[i] = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got none expected accept", i);
        end
    endtask

    // Returns at the falling edge where done is seen; at = cycle index.
    task automatic wait_done(input int i, input int limit, output int at);
        at = -1;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: got none expected pulse within %0d", i, limit);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int acc, acc2, at;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]   = 1'b0;
            valid[i]   = 1'b1;
            abort_s[i] = 1'b0;
            cnt_s[i]   = 8'd1;
            on_s[i]    = 16'd1;
            off_s[i]   = 16'd1;
        end

        // 1: reset held 3 cycles with cmd_valid high
        step(3);
        chk("t1_ready", 0, 32'(ready[0]), 0);
        chk("t1_led",   0, 32'(led[0]),   1);
        chk("t1_busy",  0, 32'(busy[0]),  0);
        chk("t1_done",  0, 32'(done[0]),  0);
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            rst_n[i] = 1'b1;
        end
        step(2);
        chk("t1_no_accept", 0, 32'(busy[0]), 0);

        // 2: count=2 on=3 off=1 -> done 32 cycles after accept
        issue(0, 2, 3, 1, 1'b0, acc);
        chk("t2_led_on", 0, 32'(led[0]), 0);
        wait_done(0, 100, at);
        chk("t2_done_latency", 0, 32'(at - acc), 32);
        step(1);
        chk("t2_done_width", 0, 32'(done[0]), 0);

        // 3a: count=0 -> done the cycle right after the accepting edge
        issue(0, 0, 5, 5, 1'b0, acc);
        chk("t3_busy", 0, 32'(busy[0]), 0);
        wait_done(0, 10, at);
        chk("t3_zero_count_latency", 0, 32'(at - acc), 0);
        step(1);

        // 3b: on=0 off=0 count=1 -> 4 low + 4 high
        issue(0, 1, 0, 0, 1'b0, acc);
        wait_done(0, 50, at);
        chk("t3_zero_period_latency", 0, 32'(at - acc), 8);
        step(1);

        // 4: abort 10 cycles after accept
        issue(0, 5, 2, 1, 1'b0, acc);
        step(9);
        abort_s[0] = 1'b1;
        step(1);
        chk("t4_busy", 0, 32'(busy[0]), 0);
        chk("t4_led",  0, 32'(led[0]),  1);
        chk("t4_ready_blocked", 0, 32'(ready[0]), 0);
        step(1);
        abort_s[0] = 1'b0;
        #1;
        chk("t4_ready", 0, 32'(ready[0]), 1);
        step(40);

        // 5: cmd_valid held high, second command in done cycle of first
        issue(0, 1, 1, 1, 1'b1, acc);
        step(2);
        cnt_s[0] = 8'd1;
        on_s[0]  = 16'd2;
        off_s[0] = 16'd1;
        wait_done(0, 50, at);
        chk("t5_first_latency", 0, 32'(at - acc), 8);
        chk("t5_ready_in_done", 0, 32'(ready[0]), 1);
        step(1);
        acc2 = cyc;
        valid[0] = 1'b0;
        chk("t5_second_accepted", 0, 32'(busy[0]), 1);
        wait_done(0, 50, at);
        chk("t5_second_latency", 0, 32'(at - acc2), 12);
        step(1);

        // 6: TICK_DIV=1, count=3 on=1 off=2 -> done at cycle 9
        issue(1, 3, 1, 2, 1'b0, acc);
        wait_done(1, 40, at);
        chk("t6_done_latency", 1, 32'(at - acc), 9);
        step(1);
        issue(1, 3, 1, 2, 1'b0, acc);
        step(3);
        rst_n[1] = 1'b0;
        step(1);
        chk("t6_reset_busy", 1, 32'(busy[1]), 0);
        chk("t6_reset_led",  1, 32'(led[1]),  1);
        rst_n[1] = 1'b1;
        step(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
